// File: rtl/register_sync_mc_if.sv
// Bus bundle for register_sync_mc: source register values and resend request in,
// busy flag and synchronized register image with per-channel update strobes out.
interface register_sync_mc_if #(
  parameter int NUM_CH   = 4,
  parameter int CH_WIDTH = 16
);
  logic [NUM_CH*CH_WIDTH-1:0] reg_i;
  logic                       resend_i;
  logic                       busy_o;
  logic [NUM_CH*CH_WIDTH-1:0] reg_o;
  logic [NUM_CH-1:0]          upd_o;

  modport master (output reg_i, resend_i, input busy_o, reg_o, upd_o);
  modport slave  (input reg_i, resend_i, output busy_o, reg_o, upd_o);
endinterface

// File: rtl/register_sync_mc.sv
// Multi-channel register synchronizer: changed channels are sent one at a time, round
// robin, from clk_i to clk_o with a toggle req/ack handshake over held data.
module register_sync_mc #(
  parameter int                         NUM_CH      = 4,
  parameter int                         CH_WIDTH    = 16,
  parameter logic [NUM_CH*CH_WIDTH-1:0] CH_PRESET   = '0,
  parameter int                         SYNC_STAGES = 3,
  parameter string                      INIT_SEND   = "OFF"
) (
  input  logic              clk_i,
  input  logic              nrst_i,
  input  logic              clk_o,
  input  logic              clk_i_en,
  input  logic              clk_o_en,
  register_sync_mc_if.slave bus
);
  localparam int                IDX_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [NUM_CH-1:0] RESEND_RST = (INIT_SEND == "ON") ? {NUM_CH{1'b1}} : '0;

  typedef enum logic {S_IDLE, S_WAIT_ACK} state_e;

  // NOTE: reset asserts asynchronously but each domain leaves it only after a clean
  // run of enabled edges, so no flop sees reset release near its own clock edge.
  logic [SYNC_STAGES-1:0] src_rst_q, dst_rst_q;
  logic                   src_rst_n, dst_rst_n;

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i)       src_rst_q <= '0;
    else if (clk_i_en) src_rst_q <= {src_rst_q[SYNC_STAGES-2:0], 1'b1};
  end

  always_ff @(posedge clk_o or negedge nrst_i) begin
    if (!nrst_i)       dst_rst_q <= '0;
    else if (clk_o_en) dst_rst_q <= {dst_rst_q[SYNC_STAGES-2:0], 1'b1};
  end

  assign src_rst_n = src_rst_q[SYNC_STAGES-1];
  assign dst_rst_n = dst_rst_q[SYNC_STAGES-1];

  // ---------------- source domain ----------------
  state_e                     state_q, state_d;
  logic                       req_tgl_q, req_tgl_d;
  logic [CH_WIDTH-1:0]        hold_data_q, hold_data_d;
  logic [IDX_W-1:0]           hold_idx_q, hold_idx_d;
  logic [IDX_W-1:0]           last_ch_q, last_ch_d;
  logic [NUM_CH*CH_WIDTH-1:0] shadow_q, shadow_d;
  logic [NUM_CH-1:0]          resend_q, resend_d;
  logic [SYNC_STAGES-1:0]     ack_sync_q;
  logic                       src_live_q;
  logic                       ack_tgl_q;

  logic [NUM_CH-1:0]   pending;
  logic                hi_found, lo_found, sel_found;
  logic [IDX_W-1:0]    hi_idx, lo_idx, sel_idx;
  logic [CH_WIDTH-1:0] sel_data;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      pending[c] = (bus.reg_i[c*CH_WIDTH +: CH_WIDTH] != shadow_q[c*CH_WIDTH +: CH_WIDTH])
                   | resend_q[c];
    end
  end

  // Scanning downward leaves the lowest pending index above last_ch in hi_idx and the
  // lowest at or below it in lo_idx; preferring hi gives the round-robin wrap.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (pending[c]) begin
        if (c > int'(last_ch_q)) begin
          hi_found = 1'b1;
          hi_idx   = IDX_W'(c);
        end else begin
          lo_found = 1'b1;
          lo_idx   = IDX_W'(c);
        end
      end
    end
    sel_found = hi_found | lo_found;
    sel_idx   = hi_found ? hi_idx : lo_idx;
    sel_data  = bus.reg_i[sel_idx*CH_WIDTH +: CH_WIDTH];
  end

  // NOTE: every output of this block is defaulted first, so no path leaves a value
  // unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    req_tgl_d   = req_tgl_q;
    hold_data_d = hold_data_q;
    hold_idx_d  = hold_idx_q;
    last_ch_d   = last_ch_q;
    shadow_d    = shadow_q;
    resend_d    = bus.resend_i ? {NUM_CH{1'b1}} : resend_q;
    case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          state_d     = S_WAIT_ACK;
          req_tgl_d   = ~req_tgl_q;
          hold_data_d = sel_data;
          hold_idx_d  = sel_idx;
          last_ch_d   = sel_idx;
          shadow_d[sel_idx*CH_WIDTH +: CH_WIDTH] = sel_data;
          resend_d[sel_idx] = 1'b0;
        end
      end
      S_WAIT_ACK: if (ack_sync_q[SYNC_STAGES-1] == req_tgl_q) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge src_rst_n) begin
    if (!src_rst_n) begin
      state_q     <= S_IDLE;
      req_tgl_q   <= 1'b0;
      hold_data_q <= '0;
      hold_idx_q  <= '0;
      last_ch_q   <= IDX_W'(NUM_CH - 1);
      shadow_q    <= CH_PRESET;
      resend_q    <= RESEND_RST;
      ack_sync_q  <= '0;
      src_live_q  <= 1'b0;
    end else if (clk_i_en) begin
      state_q     <= state_d;
      req_tgl_q   <= req_tgl_d;
      hold_data_q <= hold_data_d;
      hold_idx_q  <= hold_idx_d;
      last_ch_q   <= last_ch_d;
      shadow_q    <= shadow_d;
      resend_q    <= resend_d;
      ack_sync_q  <= {ack_sync_q[SYNC_STAGES-2:0], ack_tgl_q};
      src_live_q  <= 1'b1;
    end
  end

  assign bus.busy_o = src_live_q & ((state_q == S_WAIT_ACK) | (|pending));

  // ---------------- destination domain ----------------
  logic [SYNC_STAGES-1:0]     req_sync_q;
  logic                       req_dly_q;
  logic                       ack_tgl_d;
  logic [NUM_CH*CH_WIDTH-1:0] reg_o_q, reg_o_d;
  logic [NUM_CH-1:0]          upd_q, upd_d;
  logic                       req_seen;

  assign req_seen = req_sync_q[SYNC_STAGES-1] ^ req_dly_q;

  // hold_data/hold_idx are stable for the whole handshake, so they are read directly.
  always_comb begin
    reg_o_d   = reg_o_q;
    upd_d     = '0;
    ack_tgl_d = ack_tgl_q;
    if (req_seen) begin
      ack_tgl_d = ~ack_tgl_q;
      if (int'(hold_idx_q) < NUM_CH) begin
        reg_o_d[hold_idx_q*CH_WIDTH +: CH_WIDTH] = hold_data_q;
        upd_d[hold_idx_q] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_o or negedge dst_rst_n) begin
    if (!dst_rst_n) begin
      req_sync_q <= '0;
      req_dly_q  <= 1'b0;
      ack_tgl_q  <= 1'b0;
      reg_o_q    <= CH_PRESET;
      upd_q      <= '0;
    end else if (clk_o_en) begin
      req_sync_q <= {req_sync_q[SYNC_STAGES-2:0], req_tgl_q};
      req_dly_q  <= req_sync_q[SYNC_STAGES-1];
      ack_tgl_q  <= ack_tgl_d;
      reg_o_q    <= reg_o_d;
      upd_q      <= upd_d;
    end
  end

  assign bus.reg_o = reg_o_q;
  assign bus.upd_o = upd_q;
endmodule

// File: tb/tb_register_sync_mc.sv
// Directed and randomized bench for register_sync_mc; random traffic is judged against
// a per-channel history of written values (deliveries must move forward, end on latest).
module tb_register_sync_mc;
  localparam int NUM_CH   = 4;
  localparam int CH_WIDTH = 16;

  typedef struct {
    int          ch;
    logic [15:0] val;
    logic [3:0]  upd;
  } ev_t;

  logic clk_i    = 1'b0;
  logic clk_o    = 1'b0;
  logic nrst_i   = 1'b0;
  logic clk_i_en = 1'b1;
  logic clk_o_en = 1'b1;
  int   half_i   = 5;
  int   half_o   = 7;

  int   errors = 0;
  int   checks = 0;
  bit   model_on  = 1'b0;
  bit   toggle_on = 1'b0;

  ev_t         ev_q[$];
  logic [15:0] hist[NUM_CH][$];
  int          last_idx[NUM_CH];
  int          exp_034[3] = '{0, 1, 3};
  int          exp_036[4] = '{2, 3, 0, 1};
  logic [63:0] exp_v;
  int          n_ch1;

  register_sync_mc_if #(.NUM_CH(NUM_CH), .CH_WIDTH(CH_WIDTH)) bus ();

  register_sync_mc #(
    .NUM_CH(NUM_CH), .CH_WIDTH(CH_WIDTH), .CH_PRESET('0), .SYNC_STAGES(3), .INIT_SEND("OFF")
  ) dut (
    .clk_i(clk_i), .nrst_i(nrst_i), .clk_o(clk_o),
    .clk_i_en(clk_i_en), .clk_o_en(clk_o_en), .bus(bus)
  );

  initial forever #(half_i) clk_i = ~clk_i;
  initial forever #(half_o) clk_o = ~clk_o;

  initial forever begin
    @(negedge clk_o);
    clk_o_en = toggle_on ? ~clk_o_en : 1'b1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Watches every enabled clk_o edge; a nonzero upd_o there is a fresh write.
  initial begin : monitor
    logic        en_s;
    int          ch;
    int          found;
    logic [15:0] val;
    forever begin
      @(posedge clk_o);
      en_s = clk_o_en;
      #1;
      if (en_s && bus.upd_o !== 4'b0000) begin
        ch = 0;
        for (int c = 0; c < NUM_CH; c++) if (bus.upd_o[c]) ch = c;
        check("upd_o one-hot", 64'($countones(bus.upd_o)), 64'd1);
        val = bus.reg_o[ch*CH_WIDTH +: CH_WIDTH];
        if (model_on) begin
          found = -1;
          for (int i = last_idx[ch] + 1; i < hist[ch].size(); i++)
            if (found < 0 && hist[ch][i] == val) found = i;
          check($sformatf("model ch%0d delivered %0h is a newer write", ch, val),
                64'(found >= 0), 64'd1);
          if (found >= 0) last_idx[ch] = found;
        end else begin
          ev_q.push_back('{ch, val, bus.upd_o});
        end
      end
    end
  end

  task automatic set_ch(input int ch, input logic [15:0] v);
    @(negedge clk_i);
    bus.reg_i[ch*CH_WIDTH +: CH_WIDTH] = v;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    repeat (4) @(negedge clk_i);
    while (bus.busy_o && n < 3000) begin
      @(negedge clk_i);
      n++;
    end
    check({tag, " busy_o drop within budget"}, 64'(n < 3000), 64'd1);
    repeat (3) @(posedge clk_o);
    @(negedge clk_i);
  endtask

  task automatic run_random(input int n);
    int          ch;
    logic [15:0] v;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      ch = $urandom_range(0, NUM_CH - 1);
      v  = 16'($urandom);
      bus.reg_i[ch*CH_WIDTH +: CH_WIDTH] = v;
      if (v != hist[ch][$]) hist[ch].push_back(v);
      repeat ($urandom_range(0, 6)) @(negedge clk_i);
    end
  endtask

  initial begin
    bus.reg_i    = '0;
    bus.resend_i = 1'b0;

    // reset state
    repeat (3) @(negedge clk_i);
    check("reset reg_o", bus.reg_o, 64'h0);
    check("reset upd_o", 64'(bus.upd_o), 64'h0);
    check("reset busy_o", 64'(bus.busy_o), 64'h0);
    nrst_i = 1'b1;
    repeat (10) @(negedge clk_i);
    check("idle after reset busy_o", 64'(bus.busy_o), 64'h0);
    check("no upd after reset", 64'(ev_q.size()), 64'd0);

    // single channel write
    ev_q.delete();
    set_ch(2, 16'h1234);
    wait_idle("ch2 write");
    check("ch2 write pulse count", 64'(ev_q.size()), 64'd1);
    if (ev_q.size() >= 1) check("ch2 write upd_o", 64'(ev_q[0].upd), 64'h4);
    check("ch2 write reg_o", bus.reg_o, 64'h0000_1234_0000_0000);

    // reset during a transfer, then a fresh transfer
    ev_q.delete();
    set_ch(0, 16'hBEEF);
    repeat (2) @(negedge clk_i);
    check("in flight busy_o", 64'(bus.busy_o), 64'h1);
    nrst_i = 1'b0;
    #3;
    check("mid-reset reg_o", bus.reg_o, 64'h0);
    check("mid-reset upd_o", 64'(bus.upd_o), 64'h0);
    check("mid-reset busy_o", 64'(bus.busy_o), 64'h0);
    bus.reg_i = 64'h0C0C_0000_0000_0000;
    repeat (3) @(negedge clk_i);
    nrst_i = 1'b1;
    repeat (10) @(negedge clk_i);
    wait_idle("after reset");
    check("after reset pulse count", 64'(ev_q.size()), 64'd1);
    if (ev_q.size() >= 1) begin
      check("after reset channel", 64'(ev_q[0].ch), 64'd3);
      check("after reset value", 64'(ev_q[0].val), 64'h0C0C);
    end
    check("after reset reg_o", bus.reg_o, 64'h0C0C_0000_0000_0000);

    // three channels change together
    ev_q.delete();
    @(negedge clk_i);
    bus.reg_i = {16'h3333, 16'h0000, 16'h2222, 16'h1111};
    wait_idle("three channels");
    check("three channels pulse count", 64'(ev_q.size()), 64'd3);
    for (int i = 0; i < 3 && i < ev_q.size(); i++) begin
      check($sformatf("three channels order %0d", i), 64'(ev_q[i].ch), 64'(exp_034[i]));
      check($sformatf("three channels value %0d", i), 64'(ev_q[i].val),
            64'(bus.reg_i[exp_034[i]*CH_WIDTH +: CH_WIDTH]));
    end
    check("three channels reg_o", bus.reg_o, 64'h3333_0000_2222_1111);

    // channel rewritten while its own transfer is in flight
    ev_q.delete();
    set_ch(1, 16'hAAAA);
    repeat (2) @(negedge clk_i);
    check("rewrite busy_o", 64'(bus.busy_o), 64'h1);
    set_ch(1, 16'h5555);
    wait_idle("rewrite");
    n_ch1 = 0;
    foreach (ev_q[i]) if (ev_q[i].ch == 1) n_ch1++;
    check("rewrite ch1 pulse count", 64'(n_ch1), 64'd2);
    if (ev_q.size() >= 2) begin
      check("rewrite first value", 64'(ev_q[0].val), 64'hAAAA);
      check("rewrite second value", 64'(ev_q[1].val), 64'h5555);
    end
    check("rewrite reg_o ch1", 64'(bus.reg_o[16 +: 16]), 64'h5555);

    // resend with unchanged inputs
    ev_q.delete();
    exp_v = bus.reg_i;
    @(negedge clk_i);
    bus.resend_i = 1'b1;
    @(negedge clk_i);
    bus.resend_i = 1'b0;
    wait_idle("resend");
    check("resend pulse count", 64'(ev_q.size()), 64'd4);
    for (int i = 0; i < 4 && i < ev_q.size(); i++)
      check($sformatf("resend order %0d", i), 64'(ev_q[i].ch), 64'(exp_036[i]));
    check("resend reg_o unchanged", bus.reg_o, exp_v);

    // randomized traffic, clk_o_en toggling, both clock ratios
    for (int c = 0; c < NUM_CH; c++) begin
      hist[c].delete();
      hist[c].push_back(bus.reg_i[c*CH_WIDTH +: CH_WIDTH]);
      last_idx[c] = 0;
    end
    model_on  = 1'b1;
    toggle_on = 1'b1;
    half_i = 5;
    half_o = 15;
    run_random(500);
    wait_idle("random fast clk_i");
    for (int c = 0; c < NUM_CH; c++)
      check($sformatf("random fast clk_i final ch%0d", c),
            64'(bus.reg_o[c*CH_WIDTH +: CH_WIDTH]), 64'(hist[c][$]));
    half_i = 15;
    half_o = 5;
    run_random(500);
    wait_idle("random fast clk_o");
    for (int c = 0; c < NUM_CH; c++)
      check($sformatf("random fast clk_o final ch%0d", c),
            64'(bus.reg_o[c*CH_WIDTH +: CH_WIDTH]), 64'(hist[c][$]));
    toggle_on = 1'b0;
    model_on  = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
